or_reduce_pipe: RTL and testbench
=================================

Name: or_reduce_pipe

Overview:
- Parametrised, multi-channel successor to the two-input OR gate.
- Each of CHANNELS lanes OR-reduces a WIDTH-bit slice and registers the result, with a valid strobe carried alongside.
- Per-lane live/sticky mode: sticky lanes hold a 1 until cleared.
- Used as an event/flag aggregator ahead of status registers and interrupt logic.

Parameters:
- WIDTH, 8, bits per channel reduced by OR (>=1)
- CHANNELS, 4, number of independent lanes (>=1)
- CNT_W, 16, hit-counter width (optional feature only)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low (sampled on clk; 0 = reset)
- in_valid  input  1  in is sampled this cycle
- in  input  CHANNELS*WIDTH  lane c = in[c*WIDTH +: WIDTH]
- sticky  input  CHANNELS  per-lane mode: 0 live, 1 sticky
- clear  input  1  clears sticky state (and counter)
- out_valid  output  1  out updated from a valid sample last cycle
- out  output  CHANNELS  registered per-lane OR result
- any  output  1  registered OR of the next-state out vector (same timing as out)
- hit_cnt  output  CNT_W  saturating hit count (only with OR_REDUCE_CNT_EN)

Behaviour:
- Reset (rst=0 at posedge): out=0, out_valid=0, any=0, hit_cnt=0. Reset overrides every other input.
- Reduction:
  - red[c] = |in[c*WIDTH +: WIDTH]. Combinational, not visible at ports.
  - Latency is 1 cycle: sample at edge N appears on out at N+1.
- out_valid <= in_valid every cycle. It is a pure 1-cycle delay and needs no handshake; the block never stalls.
- Per-lane next state:
  - in_valid=0, clear=0: out[c] holds.
  - in_valid=0, clear=1: out[c] <= 0 for sticky lanes; live lanes hold.
  - in_valid=1, live lane: out[c] <= red[c].
  - in_valid=1, sticky lane, clear=0: out[c] <= out[c] | red[c].
  - in_valid=1, sticky lane, clear=1: out[c] <= red[c]. Clear is applied first, then the new sample accumulates.
- sticky changing between samples takes effect on the next in_valid cycle. Switching sticky→live does not clear out; the next valid sample overwrites it.
- any <= |(next out vector). It is registered with out, so it is never combinationally derived from in.
- in_valid held high: out tracks every sample with no bubbles.
- CHANNELS=1, WIDTH=1 degenerates to a registered buffer with optional latch.

Optional Feature:
- Macro: OR_REDUCE_CNT_EN.
- Defined:
  - hit_cnt increments by 1 on each in_valid cycle where |red != 0.
  - Saturates at 2^CNT_W-1.
  - clear sets it to 0; clear plus a hit in the same cycle sets it to 1.
  - Reset value is 0.
- Undefined: the hit_cnt port and counter logic are absent. The CNT_W parameter remains but is unused.

Decomposition:
- Package or_reduce_pkg: MODE_LIVE=1'b0, MODE_STICKY=1'b1, and default parameter constants.
- Sub-module or_reduce_lane:
  - Contains one lane's reduction plus the out bit register with live/sticky/clear logic.
  - Instantiated CHANNELS times in a generate loop.
- The top level holds out_valid, any and the optional counter.

Test Plan (WIDTH=8, CHANNELS=4, CNT_W=4):
1. Reset: rst=0 for 2 cycles with in=all-ones, in_valid=1 → out=0, out_valid=0, any=0, hit_cnt=0 throughout. After release, the first valid sample appears on the following edge.
2. Live lanes, sticky=4'b0000:
   - in=32'h00_80_00_01, valid → next cycle out=4'b0101, any=1.
   - Then in=0, valid → out=4'b0000, any=0.
   - in_valid=0 with in changing → out holds.
3. Sticky, sticky=4'b1111:
   - Sequential valid samples 32'h01_00_00_00 then 32'h00_00_00_10 → out=4'b1000 then 4'b1001.
   - Then a valid sample in=0 → out stays 4'b1001.
4. Clear collision, sticky=4'b1111, out=4'b1001:
   - clear=1 with valid in=32'h00_00_FF_00 → out=4'b0010.
   - clear=1 alone → out=4'b0000.
5. Mixed mode, sticky=4'b0011:
   - Valid sample in=32'hFF_FF_FF_FF, then in=0 → out=4'b1111 then 4'b0011.
6. Counter (OR_REDUCE_CNT_EN):
   - 20 consecutive valid nonzero samples → hit_cnt saturates at 4'hF.
   - clear with a hit → 1.
   - Valid in=0 → unchanged.

Source files
------------

// File: rtl/or_reduce_pkg.sv
// -----------------------------------------------------------------------------
// or_reduce_pkg
// Shared definitions for the or_reduce_pipe flag aggregator.
//   - lane_mode_e : per-lane accumulation mode (live / sticky)
//   - DEF_*       : default parameter values used by the top and lane modules
// Optional feature macro used by the top: OR_REDUCE_CNT_EN (saturating hit count).
// -----------------------------------------------------------------------------
package or_reduce_pkg;

    // Per-lane mode as driven on the sticky input bits
    typedef enum logic {
        MODE_LIVE   = 1'b0,
        MODE_STICKY = 1'b1
    } lane_mode_e;

    // Default parameter values
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_CNT_W    = 16;

    // True when the lane should OR the new sample into its held value
    function automatic logic lane_accumulates(input lane_mode_e mode, input logic clear);
        return (mode == MODE_STICKY) && !clear;
    endfunction

endpackage : or_reduce_pkg

// File: rtl/or_reduce_lane.sv
// -----------------------------------------------------------------------------
// or_reduce_lane
// One lane of the aggregator: OR-reduces a WIDTH-bit slice and keeps the
// registered lane flag, honouring live/sticky mode and the clear strobe.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset (0 = reset)
//   in_valid_i in   slice_i is sampled this cycle
//   slice_i    in   WIDTH-bit lane data
//   sticky_i   in   lane mode: 0 live, 1 sticky
//   clear_i    in   clears sticky state
//   out_o      out  registered lane flag
//   out_d_c    out  combinational next value of the lane flag (feeds top 'any')
// -----------------------------------------------------------------------------
module or_reduce_lane
    import or_reduce_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] slice_i,
    input  logic             sticky_i,
    input  logic             clear_i,
    output logic             out_o,
    output logic             out_d_c
);

    lane_mode_e mode;
    logic       red;
    logic       out_q;
    logic       out_d;

    assign mode = lane_mode_e'(sticky_i);
    assign red  = |slice_i;

    // Next lane value; on a valid sample a clear is applied before accumulating
    always_comb begin
        out_d = out_q;
        if (in_valid_i) begin
            if (lane_accumulates(mode, clear_i)) begin
                out_d = out_q | red;
            end else begin
                out_d = red;
            end
        end else if (clear_i && (mode == MODE_STICKY)) begin
            out_d = 1'b0;
        end
    end

    // Lane flag register
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o   = out_q;
    assign out_d_c = out_d;

endmodule : or_reduce_lane

// File: rtl/or_reduce_pipe.sv
// -----------------------------------------------------------------------------
// or_reduce_pipe
// Multi-channel registered OR-reduction flag aggregator. Each of CHANNELS lanes
// OR-reduces its WIDTH-bit slice of 'in' with one cycle of latency; lanes can be
// live (follow each sample) or sticky (hold a 1 until cleared).
//
// Optional feature: define OR_REDUCE_CNT_EN to add the saturating hit_cnt
// output, counting valid cycles in which any lane reduced to 1.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset (0 = reset)
//   in_valid   in   'in' is sampled this cycle
//   in         in   CHANNELS*WIDTH data, lane c = in[c*WIDTH +: WIDTH]
//   sticky     in   per-lane mode: 0 live, 1 sticky
//   clear      in   clears sticky lane state (and hit counter)
//   out_valid  out  'out' was updated from a valid sample last cycle
//   out        out  registered per-lane OR result
//   any        out  registered OR of all lanes (same timing as 'out')
//   hit_cnt    out  saturating hit count (OR_REDUCE_CNT_EN only)
// -----------------------------------------------------------------------------
module or_reduce_pipe
    import or_reduce_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS-1:0]       sticky,
    input  logic                      clear,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       out,
    output logic                      any
`ifdef OR_REDUCE_CNT_EN
    ,
    output logic [CNT_W-1:0]          hit_cnt
`endif
);

    // Elaboration-time parameter sanity checks
    if (WIDTH < 1) begin : g_bad_width
        $error("or_reduce_pipe: WIDTH must be >= 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("or_reduce_pipe: CHANNELS must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("or_reduce_pipe: CNT_W must be >= 1");
    end

    logic [CHANNELS-1:0] lane_out;
    logic [CHANNELS-1:0] lane_out_d;

    // Per-lane reduction and flag registers
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        or_reduce_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .in_valid_i (in_valid),
            .slice_i    (in[c*WIDTH +: WIDTH]),
            .sticky_i   (sticky[c]),
            .clear_i    (clear),
            .out_o      (lane_out[c]),
            .out_d_c    (lane_out_d[c])
        );
    end

    logic valid_q;
    logic valid_d;
    logic any_q;
    logic any_d;

    // 'any' is taken from the lanes' next state so it lines up with 'out'
    always_comb begin
        valid_d = in_valid;
        any_d   = |lane_out_d;
    end

    // Valid strobe and summary flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            any_q   <= any_d;
        end
    end

    assign out_valid = valid_q;
    assign out       = lane_out;
    assign any       = any_q;

`ifdef OR_REDUCE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             hit;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_base;

    // Any lane reducing to 1 is equivalent to the whole input being nonzero
    assign hit = in_valid && (|in);

    // Clear zeroes the count first so a same-cycle hit lands at 1
    always_comb begin
        cnt_base = clear ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (hit && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    // Hit counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
`endif

endmodule : or_reduce_pipe

// File: tb/tb_or_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_or_reduce_pipe
// Self-checking bench for or_reduce_pipe (WIDTH=8, CHANNELS=4, CNT_W=4).
// Stimulus is driven on the falling edge; the expected response for each cycle
// is pushed into a queue and a monitor pops and compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_or_reduce_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned CW = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [CH*W-1:0] din;
    logic [CH-1:0]   sticky;
    logic            clear;
    logic            out_valid;
    logic [CH-1:0]   out;
    logic            any;
`ifdef OR_REDUCE_CNT_EN
    logic [CW-1:0]   hit_cnt;
`endif

    or_reduce_pipe #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .sticky    (sticky),
        .clear     (clear),
        .out_valid (out_valid),
        .out       (out),
        .any       (any)
`ifdef OR_REDUCE_CNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] o;
        logic       a;
        int         cnt;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: one flag per lane and an integer hit count
    bit m_flag[CH];
    int m_cnt = 0;

    task automatic check(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, expv);
        end
    endtask

    // Apply one cycle of stimulus and record the expected outputs after the edge
    task automatic step(input logic r, input logic v, input logic [31:0] d,
                        input logic [3:0] s, input logic c);
        exp_t e;
        bit   lane_hit;
        bit   some_hit;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        din      = d;
        sticky   = s;
        clear    = c;
        some_hit = (d != 0);
        if (!r) begin
            for (int i = 0; i < CH; i++) m_flag[i] = 0;
            m_cnt = 0;
            e.v   = 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                lane_hit = (((d >> (i * W)) & 32'hFF) != 0);
                if (v) begin
                    if (s[i] && !c) m_flag[i] = m_flag[i] || lane_hit;
                    else            m_flag[i] = lane_hit;
                end else if (c && s[i]) begin
                    m_flag[i] = 0;
                end
            end
            if (c) m_cnt = 0;
            if (v && some_hit && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            e.v = v;
        end
        e.o = 4'b0;
        e.a = 1'b0;
        for (int i = 0; i < CH; i++) begin
            e.o[i] = m_flag[i];
            if (m_flag[i]) e.a = 1'b1;
        end
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_valid", int'(out_valid), int'(e.v));
                check("out", int'(out), int'(e.o));
                check("any", int'(any), int'(e.a));
`ifdef OR_REDUCE_CNT_EN
                check("hit_cnt", int'(hit_cnt), e.cnt);
`endif
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  rs;
        rst      = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        sticky   = '0;
        clear    = 1'b0;

        // Reset overrides a valid all-ones sample
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0);

        // Live lanes
        step(1'b1, 1'b1, 32'h0080_0001, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0000, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 32'h0101_0101, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0000, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 32'hA5A5_0000, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0000, 4'b0000, 1'b0);

        // Sticky accumulation
        step(1'b1, 1'b1, 32'h0100_0000, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0010, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0000, 4'b1111, 1'b0);

        // Clear collision, then clear alone
        step(1'b1, 1'b1, 32'h0000_FF00, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 32'h0000_0000, 4'b1111, 1'b1);

        // Mixed mode
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0011, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0000, 4'b0011, 1'b0);

        // Clear alone leaves live lanes untouched
        step(1'b1, 1'b1, 32'hFF00_0000, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0000, 4'b0000, 1'b1);

        // Counter saturation, clear with hit, valid zero sample
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h0000_0001 << i, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0100, 4'b0000, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0000, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0);

        // Randomised traffic with occasional reset and mode changes
        rs = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            rd = '0;
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 1) == 1) rd[i*W +: W] = 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 15) == 0) rs = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0), rd, rs,
                 ($urandom_range(0, 7) == 0));
        end

        // Drain the scoreboard; anything left over means the monitor stalled
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_or_reduce_pipe
